// File: rtl/ram32_ctrl.sv
// Controller for a 128 x 32 single-port RAM on a shared bidirectional data bus.
// Serves READ, WRITE, CLEAR (zero-fill) and flags the reserved opcode as an error.
module ram32_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [6:0]  ram_addr,
  inout  wire  [31:0] ram_data,
  output logic        ram_wre,
  output logic        busy
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, WR1, WR2, WREL, CLR, CLR_END, RESP} state_t;

  state_t      state_r;
  state_t      next_s;
  logic        accept_s;
  logic [31:0] dout_r;
  logic [6:0]  cnt_r;

  // The bus enable is the ram_wre flop itself, so a reset releases the bus at once.
  assign ram_data = ram_wre ? dout_r : {32{1'bz}};
  assign accept_s = req_valid & req_ready;

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (req_op)
            OP_RD:   next_s = RD;
            OP_WR:   next_s = WR1;
            OP_CLR:  next_s = CLR;
            default: next_s = RESP;
          endcase
        end else begin
          next_s = IDLE;
        end
      end
      RD:      next_s = RESP;
      WR1:     next_s = WR2;
      WR2:     next_s = WREL;
      WREL:    next_s = RESP;
      CLR: begin
        if (cnt_r == 7'd127) begin
          next_s = CLR_END;
        end else begin
          next_s = CLR;
        end
      end
      CLR_END: next_s = RESP;
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register and control outputs, all registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ram_wre   <= 1'b0;
    end else begin
      state_r   <= next_s;
      req_ready <= (next_s == IDLE);
      busy      <= (next_s != IDLE);
      rsp_valid <= (next_s == RESP);
      ram_wre   <= (next_s == WR1) || (next_s == WR2) || (next_s == CLR);
      // Only the reserved opcode jumps straight from IDLE to RESP.
      if (next_s == RESP) begin
        rsp_err <= (state_r == IDLE);
      end
    end
  end

  // Address, write data, clear counter and read-result datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= 7'd0;
      dout_r    <= 32'd0;
      cnt_r     <= 7'd0;
      rsp_rdata <= 32'd0;
    end else begin
      if (accept_s) begin
        dout_r   <= (req_op == OP_WR) ? req_wdata : 32'd0;
        cnt_r    <= 7'd0;
        ram_addr <= (req_op == OP_CLR) ? 7'd0 : req_addr;
      end else if ((state_r == CLR) && (cnt_r != 7'd127)) begin
        cnt_r    <= cnt_r + 7'd1;
        ram_addr <= cnt_r + 7'd1;
      end
      if (state_r == RD) begin
        rsp_rdata <= ram_data;
      end else if ((state_r == CLR_END) || (accept_s && (req_op == 2'b11))) begin
        rsp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ram32_ctrl.sv
// Self-checking bench for ram32_ctrl: a behavioural RAM on the shared bus, a
// directed vector table, hand-written corner sequences and randomized traffic.
module tb_ram32_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [6:0]  req_addr = 7'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, ram_wre, busy;
  logic [31:0] rsp_rdata;
  logic [6:0]  ram_addr;
  wire  [31:0] ram_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic [31:0] ref_rdata;
  logic        prev_rv = 1'b0;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [12];

  ram32_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wre(ram_wre), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: drives the bus whenever the controller is not writing.
  assign ram_data = ram_wre ? {32{1'bz}} : mem[ram_addr];
  always @(posedge clk) if (ram_wre) mem[ram_addr] <= ram_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle bus and pulse-width monitor.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("bus_no_x", {31'd0, $isunknown(ram_data)}, 32'd0);
      if (!ram_wre) check("bus_released", ram_data, mem[ram_addr]);
      check("rsp_one_cycle", {31'd0, prev_rv & rsp_valid}, 32'd0);
      prev_rv = rsp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // Reference behaviour: latency, error and read result of one request.
  task automatic model(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                       output int lat, output logic err, output logic [31:0] rd);
    err = 1'b0;
    case (op)
      2'b00: begin lat = 2; ref_rdata = ref_mem[a]; end
      2'b01: begin lat = 4; ref_mem[a] = d; end
      2'b10: begin lat = 130; ref_rdata = 32'd0; for (int i = 0; i < 128; i++) ref_mem[i] = 32'd0; end
      default: begin lat = 1; err = 1'b1; ref_rdata = 32'd0; end
    endcase
    rd = ref_rdata;
  endtask

  // Issue one request (starting at a negedge) and measure its response.
  task automatic run_txn(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                         output int lat, output logic err, output logic [31:0] rd);
    int w = 0;
    int busy_lo = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    while (!req_ready && w < 300) begin @(negedge clk); w++; end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk); lat++;
      if (!busy) busy_lo++;
      if (rsp_valid) break;
    end
    err = rsp_err; rd = rsp_rdata;
    check("busy_during_op", busy_lo, 32'd0);
  endtask

  task automatic txn_vs_model(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    int lat, elat;
    logic err, eerr;
    logic [31:0] rd, erd;
    run_txn(op, a, d, lat, err, rd);
    model(op, a, d, elat, eerr, erd);
    check("latency", lat, elat);
    check("rsp_err", {31'd0, err}, {31'd0, eerr});
    check("rsp_rdata", rd, erd);
  endtask

  initial begin
    int lat, elat, n, nrdy, nrv;
    logic err, eerr;
    logic [31:0] rd, erd;

    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    ref_rdata = 32'd0;

    tbl[0]  = '{2'b01, 7'd5,   32'hDEADBEEF, 4,   1'b0, 32'h00000000};
    tbl[1]  = '{2'b00, 7'd5,   32'h0,        2,   1'b0, 32'hDEADBEEF};
    tbl[2]  = '{2'b01, 7'd3,   32'hA5A5A5A5, 4,   1'b0, 32'hDEADBEEF};
    tbl[3]  = '{2'b11, 7'd3,   32'h0,        1,   1'b1, 32'h00000000};
    tbl[4]  = '{2'b00, 7'd3,   32'h0,        2,   1'b0, 32'hA5A5A5A5};
    tbl[5]  = '{2'b01, 7'd0,   32'h00001234, 4,   1'b0, 32'hA5A5A5A5};
    tbl[6]  = '{2'b01, 7'd127, 32'h00001234, 4,   1'b0, 32'hA5A5A5A5};
    tbl[7]  = '{2'b00, 7'd127, 32'h0,        2,   1'b0, 32'h00001234};
    tbl[8]  = '{2'b10, 7'd0,   32'h0,        130, 1'b0, 32'h00000000};
    tbl[9]  = '{2'b00, 7'd0,   32'h0,        2,   1'b0, 32'h00000000};
    tbl[10] = '{2'b00, 7'd64,  32'h0,        2,   1'b0, 32'h00000000};
    tbl[11] = '{2'b00, 7'd127, 32'h0,        2,   1'b0, 32'h00000000};

    // Reset state.
    #12;
    check("rst_ram_wre", {31'd0, ram_wre}, 32'd0);
    check("rst_ram_addr", {25'd0, ram_addr}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;
    check("ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'd0, req_ready}, 32'd1);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, lat, err, rd);
      model(tbl[i].op, tbl[i].addr, tbl[i].wdata, elat, eerr, erd);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
    end

    // READ held valid during a CLEAR is taken only in the IDLE cycle after RESP.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 7'd0;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_op = 2'b00; req_addr = 7'd9;
    n = 0; nrdy = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (req_ready) nrdy++;
      if (rsp_valid) break;
    end
    model(2'b10, 7'd0, 32'd0, elat, eerr, erd);
    check("hold_clear_latency", n, 32'd130);
    check("hold_ready_low", nrdy, 32'd0);
    @(negedge clk);
    check("hold_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check("hold_rd_cycle1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("hold_rd_cycle2", {31'd0, rsp_valid}, 32'd1);
    model(2'b00, 7'd9, 32'd0, elat, eerr, erd);
    check("hold_rd_data", rsp_rdata, erd);

    // Reset in the middle of a CLEAR, at counter value 50.
    txn_vs_model(2'b01, 7'd49, 32'h11111111);
    txn_vs_model(2'b01, 7'd50, 32'hCAFEF00D);
    req_valid = 1'b1; req_op = 2'b10;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check("clr_addr_50", {25'd0, ram_addr}, 32'd50);
    check("clr_wre_50", {31'd0, ram_wre}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_wre_drop", {31'd0, ram_wre}, 32'd0);
    check("async_bus_release", ram_data, mem[ram_addr]);
    check("async_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) ref_mem[i] = 32'd0;
    ref_rdata = 32'd0;
    nrv = 0;
    repeat (140) begin @(negedge clk); if (rsp_valid) nrv++; end
    check("no_rsp_after_reset", nrv, 32'd0);
    txn_vs_model(2'b00, 7'd49, 32'd0);
    txn_vs_model(2'b00, 7'd50, 32'd0);

    // Randomized traffic against the reference model, including back-to-back requests.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] pick;
      logic [1:0] op;
      pick = 4'($urandom_range(0, 15));
      op = (pick < 4'd7) ? 2'b00 : (pick < 4'd14) ? 2'b01 : (pick == 4'd14) ? 2'b11 : 2'b10;
      txn_vs_model(op, 7'($urandom_range(0, 127)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
